// File: rtl/gc_input_tracker.sv
`default_nettype none
// ============================================================================
// gc_input_tracker : GameCube poll snapshot -> button event FIFO + calibrated stick
// Revision 1.0
// ============================================================================
module gc_input_tracker #(
   parameter int FIFO_DEPTH = 8,
   parameter int DEADZONE   = 8
) (
   input  logic        usClock,
   input  logic        Reset_n,
   input  logic        frame_done,
   input  logic [11:0] buttons,
   input  logic [7:0]  joyX,
   input  logic [7:0]  joyY,
   input  logic        recal,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [4:0]  evt_code,
   output logic        evt_overflow,
   output logic [7:0]  joyX_cal,
   output logic [7:0]  joyY_cal,
   output logic        cal_valid,
   output logic [15:0] frame_count
);
   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam int         CW       = AW + 1;
   localparam logic [8:0] C_DZ     = 9'(DEADZONE);
   localparam logic [7:0] C_CENTRE = 8'h80;

   typedef enum logic [1:0] {UNCAL = 2'd0, RUN = 2'd1, EMIT = 2'd2} state_t;

   state_t        state_q;
   logic [11:0]   prev_q, pend_chg_q, pend_btn_q;
   logic [7:0]    cx_q, cy_q, jx_q, jy_q;
   logic          cal_q, ovf_q;
   logic [15:0]   fcnt_q;
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic [4:0]    mem_q [FIFO_DEPTH];

   logic [3:0]    lsb_idx;
   logic [11:0]   lsb_mask;
   logic [11:0]   chg;
   logic          push, pop, full, push_ok;
   logic [4:0]    push_code;

   function automatic logic [7:0] calib(input logic [7:0] raw, input logic [7:0] ctr);
      logic signed [8:0] d;
      logic signed [8:0] s;
      logic [8:0]        mag;
      d = $signed({1'b0, raw}) - $signed({1'b0, ctr});
      if (d > 9'sd127)        s = 9'sd127;
      else if (d < -9'sd128)  s = -9'sd128;
      else                    s = d;
      mag = s[8] ? $unsigned(-s) : $unsigned(s);
      return (mag <= C_DZ) ? 8'h00 : s[7:0];
   endfunction

   // Scan downward so the final hit is the lowest set bit.
   always_comb begin
      lsb_idx  = 4'd0;
      lsb_mask = 12'd0;
      for (int i = 11; i >= 0; i--) begin
         if (pend_chg_q[i]) begin
            lsb_idx  = 4'(i);
            lsb_mask = 12'd1 << i;
         end
      end
   end

   assign chg       = buttons ^ prev_q;
   assign push      = (state_q == EMIT) && !recal;
   assign push_code = {pend_btn_q[lsb_idx], lsb_idx};
   assign evt_valid = (cnt_q != '0);
   assign pop       = evt_valid && evt_ready;
   assign full      = (cnt_q == CW'(FIFO_DEPTH));
   assign push_ok   = push && (!full || pop);
   assign evt_code  = evt_valid ? mem_q[rd_q] : 5'd0;

   always_ff @(posedge usClock) begin
      if (push_ok) mem_q[wr_q] <= push_code;
   end

   always_ff @(posedge usClock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= UNCAL;
         prev_q     <= '0;
         pend_chg_q <= '0;
         pend_btn_q <= '0;
         cx_q       <= C_CENTRE;
         cy_q       <= C_CENTRE;
         jx_q       <= '0;
         jy_q       <= '0;
         cal_q      <= 1'b0;
         ovf_q      <= 1'b0;
         fcnt_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         if (pop)     rd_q <= rd_q + AW'(1);
         if (push_ok) wr_q <= wr_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);

         // A dropped push or a frame arriving mid-emission both lose events.
         if (recal)
            ovf_q <= 1'b0;
         else if ((push && !push_ok) || ((state_q == EMIT) && frame_done))
            ovf_q <= 1'b1;

         if (recal) begin
            state_q    <= UNCAL;
            cal_q      <= 1'b0;
            jx_q       <= '0;
            jy_q       <= '0;
            pend_chg_q <= '0;
            cx_q       <= C_CENTRE;
            cy_q       <= C_CENTRE;
         end else begin
            case (state_q)
               UNCAL: if (frame_done) begin
                  cx_q    <= joyX;
                  cy_q    <= joyY;
                  prev_q  <= buttons;
                  cal_q   <= 1'b1;
                  state_q <= RUN;
               end
               RUN: if (frame_done) begin
                  prev_q <= buttons;
                  jx_q   <= calib(joyX, cx_q);
                  jy_q   <= calib(joyY, cy_q);
                  fcnt_q <= fcnt_q + 16'd1;
                  if (chg != '0) begin
                     pend_chg_q <= chg;
                     pend_btn_q <= buttons;
                     state_q    <= EMIT;
                  end
               end
               EMIT: begin
                  pend_chg_q <= pend_chg_q & ~lsb_mask;
                  if ((pend_chg_q & ~lsb_mask) == '0) state_q <= RUN;
               end
               default: state_q <= UNCAL;
            endcase
         end
      end
   end

   assign evt_overflow = ovf_q;
   assign joyX_cal     = jx_q;
   assign joyY_cal     = jy_q;
   assign cal_valid    = cal_q;
   assign frame_count  = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gc_input_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// Directed self-checking bench for gc_input_tracker (FIFO_DEPTH=8, DEADZONE=8).
module tb_gc_input_tracker;
   logic        usClock    = 1'b0;
   logic        Reset_n    = 1'b1;
   logic        frame_done = 1'b0;
   logic        recal      = 1'b0;
   logic        evt_ready  = 1'b0;
   logic [11:0] buttons    = 12'h000;
   logic [7:0]  joyX       = 8'h80;
   logic [7:0]  joyY       = 8'h80;
   logic        evt_valid, evt_overflow, cal_valid;
   logic [4:0]  evt_code;
   logic [7:0]  joyX_cal, joyY_cal;
   logic [15:0] frame_count;

   int checks   = 0;
   int failures = 0;

   gc_input_tracker #(.FIFO_DEPTH(8), .DEADZONE(8)) dut (
      .usClock(usClock), .Reset_n(Reset_n), .frame_done(frame_done),
      .buttons(buttons), .joyX(joyX), .joyY(joyY), .recal(recal),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_overflow(evt_overflow), .joyX_cal(joyX_cal), .joyY_cal(joyY_cal),
      .cal_valid(cal_valid), .frame_count(frame_count)
   );

   always #500 usClock = ~usClock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge usClock);
      #1;
   endtask

   task automatic frame(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y);
      buttons    = b;
      joyX       = x;
      joyY       = y;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 16'(evt_valid), 16'h0);
      chk({tag, "_code"},  16'(evt_code), 16'h0);
      chk({tag, "_ovf"},   16'(evt_overflow), 16'h0);
      chk({tag, "_jx"},    16'(joyX_cal), 16'h0);
      chk({tag, "_jy"},    16'(joyY_cal), 16'h0);
      chk({tag, "_cal"},   16'(cal_valid), 16'h0);
      chk({tag, "_fc"},    frame_count, 16'h0);
   endtask

   logic [4:0] drain_exp [8];
   logic [4:0] emit_exp  [12];

   initial begin
      drain_exp = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h19};
      emit_exp  = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                    5'h06, 5'h07, 5'h08, 5'h09, 5'h1A, 5'h1B};

      // Asynchronous reset, observed before any clock edge
      #10 Reset_n = 1'b0;
      #1  chk_reset("rst0");
      tick(); tick();
      Reset_n = 1'b1;

      // Calibration capture and deadzone
      frame(12'h000, 8'h80, 8'h80);
      chk("cap_cal", 16'(cal_valid), 16'h1);
      chk("cap_fc", frame_count, 16'd0);
      chk("cap_noevt", 16'(evt_valid), 16'h0);
      frame(12'h000, 8'h90, 8'h80);
      chk("jx_16", 16'(joyX_cal), 16'h10);
      chk("jy_0", 16'(joyY_cal), 16'h00);
      chk("fc_1", frame_count, 16'd1);
      frame(12'h000, 8'h85, 8'h80);
      chk("jx_dz5", 16'(joyX_cal), 16'h00);
      frame(12'h000, 8'h89, 8'h80);
      chk("jx_d9", 16'(joyX_cal), 16'h09);
      frame(12'h000, 8'h78, 8'h77);
      chk("jx_dzm8", 16'(joyX_cal), 16'h00);
      chk("jy_m9", 16'(joyY_cal), 16'hF7);
      chk("fc_4", frame_count, 16'd4);

      // Press START+dLEFT, then release, consumer always ready
      evt_ready = 1'b1;
      frame(12'h801, 8'h80, 8'h80);
      chk("p_t0_valid", 16'(evt_valid), 16'h0);
      chk("p_fc", frame_count, 16'd5);
      tick();
      chk("p_ev0", 16'(evt_code), 16'h10);
      tick();
      chk("p_ev1", 16'(evt_code), 16'h1B);
      tick();
      chk("p_empty", 16'(evt_valid), 16'h0);
      frame(12'h000, 8'h80, 8'h80);
      tick();
      chk("r_ev0", 16'(evt_code), 16'h00);
      chk("r_ev0v", 16'(evt_valid), 16'h1);
      tick();
      chk("r_ev1", 16'(evt_code), 16'h0B);
      tick();
      chk("r_empty", 16'(evt_valid), 16'h0);
      evt_ready = 1'b0;

      // Saturation with off-centre calibration
      recal = 1'b1; tick(); recal = 1'b0;
      chk("recal_cal", 16'(cal_valid), 16'h0);
      frame(12'h000, 8'hF0, 8'h10);
      chk("sat_cap_fc", frame_count, 16'd6);
      frame(12'h000, 8'h00, 8'hFF);
      chk("sat_neg", 16'(joyX_cal), 16'h80);
      chk("sat_pos", 16'(joyY_cal), 16'h7F);
      recal = 1'b1; tick(); recal = 1'b0;
      chk("recal_jx", 16'(joyX_cal), 16'h0);
      chk("recal_jy", 16'(joyY_cal), 16'h0);
      chk("recal_fc", frame_count, 16'd7);
      frame(12'h000, 8'h80, 8'h80);

      // Nine presses into an 8-deep FIFO with no consumer
      for (int k = 1; k <= 9; k++) begin
         frame(12'((1 << k) - 1), 8'h80, 8'h80);
         tick();
         chk("ovf_fill", 16'(evt_overflow), 16'(k == 9));
      end
      chk("full_head", 16'(evt_code), 16'h10);
      chk("full_fc", frame_count, 16'd16);

      // Clear sticky overflow, then push+pop while full
      recal = 1'b1; tick(); recal = 1'b0;
      chk("keep_ovf0", 16'(evt_overflow), 16'h0);
      chk("keep_head", 16'(evt_code), 16'h10);
      frame(12'h1FF, 8'h80, 8'h80);
      frame(12'h3FF, 8'h80, 8'h80);
      evt_ready = 1'b1;
      tick();
      chk("pp_noovf", 16'(evt_overflow), 16'h0);
      for (int j = 0; j < 8; j++) begin
         chk("drain_valid", 16'(evt_valid), 16'h1);
         chk("drain_code", 16'(evt_code), 16'(drain_exp[j]));
         tick();
      end
      chk("drain_empty", 16'(evt_valid), 16'h0);
      chk("pp_fc", frame_count, 16'd17);

      // 12-bit change with a second frame arriving during emission
      frame(12'hC00, 8'h80, 8'h80);
      chk("em_fc", frame_count, 16'd18);
      frame(12'h000, 8'h90, 8'h80);
      chk("ign_fc", frame_count, 16'd18);
      chk("ign_ovf", 16'(evt_overflow), 16'h1);
      chk("ign_jx", 16'(joyX_cal), 16'h0);
      chk("em_head0", 16'(evt_code), 16'(emit_exp[0]));
      for (int n = 1; n < 12; n++) begin
         tick();
         chk("em_head", 16'(evt_code), 16'(emit_exp[n]));
      end
      tick();
      chk("em_empty", 16'(evt_valid), 16'h0);
      frame(12'hC00, 8'h80, 8'h80);
      chk("ign_prev_fc", frame_count, 16'd19);
      tick();
      chk("ign_prev_noevt", 16'(evt_valid), 16'h0);

      // recal during EMIT discards pending events but keeps the FIFO
      evt_ready = 1'b0;
      frame(12'hC0F, 8'h80, 8'h80);
      tick(); tick();
      recal = 1'b1; tick(); recal = 1'b0;
      chk("rc_ovf", 16'(evt_overflow), 16'h0);
      chk("rc_cal", 16'(cal_valid), 16'h0);
      chk("rc_head", 16'(evt_code), 16'h10);
      tick();
      chk("rc_hold", 16'(evt_code), 16'h10);
      frame(12'hC0F, 8'h80, 8'h80);
      chk("rc_recap", 16'(cal_valid), 16'h1);
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      chk("rc_second", 16'(evt_code), 16'h11);
      tick();
      chk("rc_last", 16'(evt_valid), 16'h1);
      frame(12'hC0F, 8'h90, 8'h80);
      chk("rc_jx", 16'(joyX_cal), 16'h10);
      chk("rc_fc", frame_count, 16'd21);

      // Asynchronous reset mid-cycle with data in flight
      #200 Reset_n = 1'b0;
      #1   chk_reset("rst1");
      tick();
      Reset_n = 1'b1;

      // recal coincident with frame_done wins
      recal = 1'b1;
      frame(12'h000, 8'h80, 8'h80);
      recal = 1'b0;
      chk("rcf_cal", 16'(cal_valid), 16'h0);
      frame(12'h000, 8'h80, 8'h80);
      chk("rcf_cap", 16'(cal_valid), 16'h1);
      chk("rcf_fc", frame_count, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
